mat_partial_accum: RTL and testbench

Downstream stage of the matrix partial-product multiplier. Consumes the 8-bit stream of partial products (a_ik·b_kj, emitted k-consecutively per result element, last flag on the final product of the matrix). Sums each group of N products into one result element C[i][j] and emits the elements in row-major order on a 16-bit AXI-Stream-style output, with last marking C[N-1][N-1]. Shares the multiplier's clock-enable so both stages advance together.

---
 rtl/mat_partial_accum.sv | 117 +++++++++++
 tb/tb_mat_partial_accum.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_partial_accum.sv
// Accumulates groups of N partial products into result elements C[i][j] and
// emits them row-major over a valid/ready output, with framing checks on s_last.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | no result element held, m_valid=0
// FULL  | result element held in m_data/m_last, m_valid=1 until taken
module mat_partial_accum #(
    parameter int N     = 2,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_e,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             o_err
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int EW = $clog2(N * N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [EW-1:0] E_LAST = EW'(N * N - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [EW-1:0]    e_q, e_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic             in_xfer;
    logic             out_xfer;
    logic             close;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] sum;

    assign m_valid = (state_q == FULL);
    assign s_ready = !m_valid || m_ready;
    assign m_data  = data_q;
    assign m_last  = last_q;
    assign o_err   = err_q;

    always_comb begin
        in_xfer  = i_clk_e && s_valid && s_ready;
        out_xfer = i_clk_e && m_valid && m_ready;
        ext      = OUT_W'(s_data);
        // k=0 starts a fresh element, so the stale accumulator is ignored
        sum      = (k_q == '0) ? ext : acc_q + ext;
        close    = in_xfer && ((k_q == K_LAST) || s_last);

        state_d = state_q;
        k_d     = k_q;
        e_d     = e_q;
        acc_d   = acc_q;
        data_d  = data_q;
        last_d  = last_q;
        err_d   = err_q;

        if (in_xfer) begin
            if (close) begin
                data_d = sum;
                last_d = (e_q == E_LAST) || s_last;
                k_d    = '0;
                e_d    = (s_last || (e_q == E_LAST)) ? '0 : e_q + 1'b1;
            end else begin
                acc_d = sum;
                k_d   = k_q + 1'b1;
            end
            if (s_last && ((k_q != K_LAST) || (e_q != E_LAST)))
                err_d = 1'b1;
            if (close && !s_last && (k_q == K_LAST) && (e_q == E_LAST))
                err_d = 1'b1;
        end

        case (state_q)
            EMPTY: if (close) state_d = FULL;
            FULL: begin
                if (close)         state_d = FULL;
                else if (out_xfer) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            k_q     <= '0;
            e_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (i_clk_e) begin
            state_q <= state_d;
            k_q     <= k_d;
            e_q     <= e_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mat_partial_accum.sv
// Bench for mat_partial_accum: directed matrix streams plus randomized traffic
// checked against a sum-of-groups reference model.
module tb_mat_partial_accum;
    logic        i_clk = 1'b0;
    logic        i_rst, i_clk_e, s_valid, s_last, m_ready;
    logic [7:0]  s_data;
    logic        s_ready, m_valid, m_last, o_err;
    logic [15:0] m_data;
    logic        s_ready8, m_valid8, m_last8, o_err8;
    logic [7:0]  m_data8;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int mode    = 0;

    logic [15:0] cap_d[$];
    bit          cap_l[$];
    logic [7:0]  cap_d8[$];

    int unsigned prods[8]  = '{5, 14, 6, 16, 15, 28, 18, 32};
    int unsigned matres[4] = '{19, 22, 43, 50};

    mat_partial_accum #(.N(2), .IN_W(8), .OUT_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_e(i_clk_e),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .o_err(o_err)
    );

    mat_partial_accum #(.N(2), .IN_W(8), .OUT_W(8)) dut8 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_e(i_clk_e),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready8),
        .m_data(m_data8), .m_valid(m_valid8), .m_last(m_last8), .m_ready(m_ready),
        .o_err(o_err8)
    );

    always #5 i_clk = ~i_clk;

    // Inputs only change just after the rising edge, so the falling edge sees
    // exactly what the next rising edge will act on.
    always @(negedge i_clk) begin
        if (!i_rst && i_clk_e && m_valid && m_ready) begin
            cap_d.push_back(m_data);
            cap_l.push_back(m_last);
        end
        if (!i_rst && i_clk_e && m_valid8 && m_ready)
            cap_d8.push_back(m_data8);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
        case (mode)
            0: begin i_clk_e = 1'b1; m_ready = 1'b1; end
            2: begin i_clk_e = (cyc % 3 == 0); m_ready = 1'b1; end
            3: begin i_clk_e = ($urandom_range(0, 3) != 0); m_ready = 1'($urandom_range(0, 1)); end
            default: ;
        endcase
    endtask

    task automatic push(input logic [7:0] d, input bit last);
        bit fire;
        int n;
        n = 0;
        s_data = d; s_last = last; s_valid = 1'b1;
        do begin
            #1;
            fire = i_clk_e && s_ready;
            step();
            n++;
        end while (!fire && n < 200);
        s_valid = 1'b0; s_last = 1'b0;
        vectors++;
        if (!fire) begin
            errors++;
            $display("FAIL push_timeout: product %0d not accepted, accepted=%0d required=1", d, fire);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_valid && n < 100) begin step(); n++; end
        step();
        vectors++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: m_valid=%b required=0", m_valid);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    task automatic clear_caps();
        cap_d.delete(); cap_l.delete(); cap_d8.delete();
    endtask

    task automatic test_reset();
        mode = 0;
        i_rst = 1'b1;
        step(); step();
        #1;
        vectors++;
        if ({m_valid, m_last, o_err, s_ready} !== 4'b0001 || m_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b last=%b err=%b ready=%b data=%0d required 0,0,0,1,0",
                     m_valid, m_last, o_err, s_ready, m_data);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_basic();
        mode = 0; do_reset(); clear_caps();
        for (int i = 0; i < 8; i++) begin
            push(8'(prods[i]), i == 7);
            vectors++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_ready: product %0d s_ready=%b required=1", i, s_ready);
            end
            if (i % 2 == 1) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== 16'(matres[i/2]) || m_last !== (i == 7)) begin
                    errors++;
                    $display("FAIL basic_latency: elem %0d valid=%b data=%0d last=%b required 1,%0d,%b",
                             i/2, m_valid, m_data, m_last, matres[i/2], (i == 7));
                end
            end
        end
        drain();
        vectors++;
        if (cap_d.size() != 4 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: outputs=%0d err=%b required 4,0", cap_d.size(), o_err);
        end
        for (int i = 0; i < 4 && i < cap_d.size(); i++) begin
            vectors++;
            if (cap_d[i] !== 16'(matres[i]) || cap_l[i] !== (i == 3)) begin
                errors++;
                $display("FAIL basic_out: elem %0d data=%0d last=%b required %0d,%b",
                         i, cap_d[i], cap_l[i], matres[i], (i == 3));
            end
        end
    endtask

    task automatic test_stall();
        mode = 0; do_reset(); clear_caps();
        push(8'd5, 1'b0); push(8'd14, 1'b0);
        s_data = 8'd6; s_valid = 1'b1; s_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_ready = 1'b0;
            #1;
            vectors++;
            if (m_valid !== 1'b1 || m_data !== 16'd19 || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b data=%0d ready=%b required 1,19,0",
                         i, m_valid, m_data, s_ready);
            end
            @(posedge i_clk); #1;
        end
        m_ready = 1'b1;
        vectors++;
        if (cap_d.size() != 0) begin
            errors++;
            $display("FAIL stall_leak: outputs=%0d required 0", cap_d.size());
        end
        for (int i = 2; i < 8; i++) push(8'(prods[i]), i == 7);
        drain();
        vectors++;
        if (cap_d.size() != 4) begin
            errors++;
            $display("FAIL stall_count: outputs=%0d required 4", cap_d.size());
        end
        for (int i = 0; i < 4 && i < cap_d.size(); i++) begin
            vectors++;
            if (cap_d[i] !== 16'(matres[i]) || cap_l[i] !== (i == 3)) begin
                errors++;
                $display("FAIL stall_out: elem %0d data=%0d last=%b required %0d,%b",
                         i, cap_d[i], cap_l[i], matres[i], (i == 3));
            end
        end
    endtask

    task automatic test_clk_en();
        bit fire, ce, pre_v;
        logic [15:0] pre_d;
        int n;
        mode = 0; do_reset(); clear_caps();
        mode = 2;
        for (int i = 0; i < 8; i++) begin
            s_data = 8'(prods[i]); s_last = (i == 7); s_valid = 1'b1;
            n = 0;
            do begin
                #1;
                pre_v = m_valid; pre_d = m_data; ce = i_clk_e;
                fire = ce && s_ready;
                step();
                n++;
                if (!ce) begin
                    vectors++;
                    if (m_valid !== pre_v || m_data !== pre_d) begin
                        errors++;
                        $display("FAIL clken_hold: valid=%b data=%0d required %b,%0d",
                                 m_valid, m_data, pre_v, pre_d);
                    end
                end
            end while (!fire && n < 200);
            s_valid = 1'b0; s_last = 1'b0;
        end
        drain();
        vectors++;
        if (cap_d.size() != 4) begin
            errors++;
            $display("FAIL clken_count: outputs=%0d required 4", cap_d.size());
        end
        for (int i = 0; i < 4 && i < cap_d.size(); i++) begin
            vectors++;
            if (cap_d[i] !== 16'(matres[i]) || cap_l[i] !== (i == 3)) begin
                errors++;
                $display("FAIL clken_out: elem %0d data=%0d last=%b required %0d,%b",
                         i, cap_d[i], cap_l[i], matres[i], (i == 3));
            end
        end
        mode = 0;
    endtask

    task automatic test_wrap();
        mode = 0; do_reset(); clear_caps();
        push(8'd255, 1'b0); push(8'd255, 1'b0);
        vectors++;
        if (m_data !== 16'd510 || m_data8 !== 8'd254) begin
            errors++;
            $display("FAIL wrap: data16=%0d data8=%0d required 510,254", m_data, m_data8);
        end
        drain();
    endtask

    task automatic test_short();
        logic [15:0] exp_d[6] = '{19, 6, 19, 22, 43, 50};
        bit          exp_l[6] = '{0, 1, 0, 0, 0, 1};
        mode = 0; do_reset(); clear_caps();
        push(8'd5, 1'b0); push(8'd14, 1'b0); push(8'd6, 1'b1);
        vectors++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL short_err: o_err=%b required 1", o_err);
        end
        for (int i = 0; i < 8; i++) push(8'(prods[i]), i == 7);
        drain();
        vectors++;
        if (cap_d.size() != 6 || o_err !== 1'b1) begin
            errors++;
            $display("FAIL short_count: outputs=%0d err=%b required 6,1", cap_d.size(), o_err);
        end
        for (int i = 0; i < 6 && i < cap_d.size(); i++) begin
            vectors++;
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL short_out: elem %0d data=%0d last=%b required %0d,%b",
                         i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    // Runs straight after test_short so o_err is already set going into reset.
    task automatic test_mid_reset();
        mode = 0;
        push(8'd5, 1'b0); push(8'd14, 1'b0); push(8'd6, 1'b0);
        do_reset();
        #1;
        vectors++;
        if (m_valid !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: valid=%b err=%b required 0,0", m_valid, o_err);
        end
        clear_caps();
        for (int i = 0; i < 8; i++) push(8'(prods[i]), i == 7);
        drain();
        vectors++;
        if (cap_d.size() != 4) begin
            errors++;
            $display("FAIL midreset_count: outputs=%0d required 4", cap_d.size());
        end
        for (int i = 0; i < 4 && i < cap_d.size(); i++) begin
            vectors++;
            if (cap_d[i] !== 16'(matres[i]) || cap_l[i] !== (i == 3)) begin
                errors++;
                $display("FAIL midreset_out: elem %0d data=%0d last=%b required %0d,%b",
                         i, cap_d[i], cap_l[i], matres[i], (i == 3));
            end
        end
    endtask

    task automatic test_random();
        int unsigned exp_sum[$];
        bit          exp_l[$];
        int unsigned p, sum;
        mode = 0; do_reset(); clear_caps();
        mode = 3;
        for (int m = 0; m < 12; m++) begin
            for (int el = 0; el < 4; el++) begin
                sum = 0;
                for (int k = 0; k < 2; k++) begin
                    p = $urandom_range(0, 255);
                    sum += p;
                    push(8'(p), (el == 3) && (k == 1));
                end
                exp_sum.push_back(sum);
                exp_l.push_back(el == 3);
            end
        end
        drain();
        mode = 0;
        vectors++;
        if (cap_d.size() != exp_sum.size() || cap_d8.size() != exp_sum.size() || o_err !== 1'b0) begin
            errors++;
            $display("FAIL random_count: outputs=%0d outputs8=%0d err=%b required %0d,%0d,0",
                     cap_d.size(), cap_d8.size(), o_err, exp_sum.size(), exp_sum.size());
        end
        for (int i = 0; i < exp_sum.size() && i < cap_d.size() && i < cap_d8.size(); i++) begin
            vectors++;
            if (cap_d[i] !== 16'(exp_sum[i]) || cap_l[i] !== exp_l[i] || cap_d8[i] !== 8'(exp_sum[i])) begin
                errors++;
                $display("FAIL random_out: elem %0d data=%0d data8=%0d last=%b required %0d,%0d,%b",
                         i, cap_d[i], cap_d8[i], cap_l[i], exp_sum[i] & 16'hffff, exp_sum[i] & 8'hff, exp_l[i]);
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_clk_e = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        s_data = 8'd0; m_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_clk_en();
        test_wrap();
        test_short();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
